// File: rtl/seq_alu_pkg.sv
// Shared opcode and FSM state types for the sequential ALU.
package seq_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_NOT = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } alu_state_e;

endpackage

// File: rtl/seq_alu_div.sv
// Iterative restoring divider: one quotient bit per cycle, MSB first.
// Iteration 0 runs on the start edge; done pulses for one cycle after iteration WIDTH-1.
module seq_alu_div #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] src_rem, src_quot, src_dvsr;
  logic [WIDTH-1:0] next_rem, next_quot;
  logic [WIDTH:0]   shifted, trial;

  // NOTE: every signal assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    src_rem   = start ? '0 : remainder;
    src_quot  = start ? dividend : quotient;
    src_dvsr  = start ? divisor : dvsr;
    shifted   = {src_rem, src_quot[WIDTH-1]};
    trial     = shifted - {1'b0, src_dvsr};
    // a negative trial means the divisor did not fit: restore and emit 0
    next_rem  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    next_quot = {src_quot[WIDTH-2:0], ~trial[WIDTH]};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      dvsr      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        quotient  <= next_quot;
        remainder <= next_rem;
        dvsr      <= divisor;
        cnt       <= CW'(1);
        busy      <= 1'b1;
      end else if (busy) begin
        quotient  <= next_quot;
        remainder <= next_rem;
        if (cnt == CW'(WIDTH - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshakes and a multi-cycle divider.
// Optional SEQ_ALU_REM_EN adds a registered remainder output.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             div_zero
`ifdef SEQ_ALU_REM_EN
  ,
  output logic [WIDTH-1:0] remainder
`endif
);

  alu_state_e state;
  alu_op_e    op_e;
  logic       div_start, div_busy, div_done;
  logic [WIDTH-1:0] div_quot, div_rem;

  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_carry, alu_dz;

  assign op_e      = alu_op_e'(op);
  assign in_ready  = (state == IDLE);
  assign div_start = in_valid && in_ready && (op_e == OP_DIV) && (b != '0);

  seq_alu_div #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (a),
    .divisor   (b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quot),
    .remainder (div_rem)
  );

  // Single-cycle ops; the OP_DIV arm is only captured for the b == 0 case.
  always_comb begin
    sum       = {1'b0, a} + {1'b0, b};
    prod      = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_dz    = 1'b0;
    case (op_e)
      OP_ADD: begin alu_res = sum[WIDTH-1:0];  alu_carry = sum[WIDTH]; end
      OP_SUB: begin alu_res = a - b;           alu_carry = (a < b);    end
      OP_MUL: begin alu_res = prod[WIDTH-1:0]; alu_carry = |prod[2*WIDTH-1:WIDTH]; end
      OP_DIV: begin alu_res = '1;              alu_dz = 1'b1;          end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_NOT: alu_res = ~a;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      div_zero  <= 1'b0;
`ifdef SEQ_ALU_REM_EN
      remainder <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          if (div_start) begin
            state <= DIV;
          end else begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= alu_res;
            carry     <= alu_carry;
            zero      <= (alu_res == '0);
            div_zero  <= alu_dz;
`ifdef SEQ_ALU_REM_EN
            remainder <= (op_e == OP_DIV) ? a : '0;
`endif
          end
        end
        DIV: if (div_done) begin
          state     <= DONE;
          out_valid <= 1'b1;
          result    <= div_quot;
          carry     <= 1'b0;
          zero      <= (div_quot == '0);
          div_zero  <= 1'b0;
`ifdef SEQ_ALU_REM_EN
          remainder <= div_rem;
`endif
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Divider status bits the FSM does not consume in this build.
  logic unused_div_bits;
`ifdef SEQ_ALU_REM_EN
  assign unused_div_bits = div_busy;
`else
  assign unused_div_bits = div_busy ^ (^div_rem);
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=8) with an arithmetic reference model and scoreboard queue.
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         carry, zero, div_zero;
`ifdef SEQ_ALU_REM_EN
  logic [W-1:0] remainder;
`endif

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .div_zero  (div_zero)
`ifdef SEQ_ALU_REM_EN
    ,
    .remainder (remainder)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         carry;
    logic         zero;
    logic         dz;
    logic [W-1:0] rem;
    int           lat;
    int           t_acc;
  } exp_t;

  exp_t q[$];
  bit   seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain unsigned integer arithmetic on the opcode table.
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int unsigned xi = x;
    int unsigned yi = y;
    int unsigned r  = 0;
    e.carry = 1'b0; e.dz = 1'b0; e.rem = '0; e.lat = 1; e.t_acc = 0;
    case (o)
      3'd0: begin r = xi + yi; e.carry = (r > 255); end
      3'd1: begin r = (xi - yi) & 32'hFF; e.carry = (xi < yi); end
      3'd2: begin r = xi * yi; e.carry = (r > 255); end
      3'd3: begin
        if (yi == 0) begin r = 255; e.dz = 1'b1; e.rem = x; end
        else begin r = xi / yi; e.rem = W'(xi % yi); e.lat = W + 1; end
      end
      3'd4: r = xi & yi;
      3'd5: r = xi | yi;
      3'd6: r = xi ^ yi;
      default: r = ~xi;
    endcase
    e.res  = W'(r);
    e.zero = (e.res == '0);
    return e;
  endfunction

  // Scoreboard compare on every cycle the outputs are valid.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        check("spurious_valid", q.size(), 1);
      end else begin
        check("result",   result,   q[0].res);
        check("carry",    carry,    q[0].carry);
        check("zero",     zero,     q[0].zero);
        check("div_zero", div_zero, q[0].dz);
`ifdef SEQ_ALU_REM_EN
        check("remainder", remainder, q[0].rem);
`endif
        if (!seen) check("latency", int'($time) - q[0].t_acc, (q[0].lat - 1) * 10 + 5);
        if (out_ready) begin
          void'(q.pop_front());
          seen = 1'b0;
        end else begin
          seen = 1'b1;
        end
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    bit ok = 1'b0;
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ok = in_ready;
      @(posedge clk);
      if (ok) break;
      @(negedge clk);
    end
    check("accept_timeout", ok, 1);
    if (ok) begin
      e = model(o, x, y);
      e.t_acc = int'($time);
      q.push_back(e);
    end
    #1;
    in_valid = 1'b0;
    op = 3'($urandom); a = W'($urandom); b = W'($urandom);
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (q.size() == 0) begin ok = 1'b1; break; end
    end
    check("drain_timeout", ok, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_in_ready"},  in_ready,  1);
    check({tag, "_result"},    result,    0);
    check({tag, "_carry"},     carry,     0);
    check({tag, "_zero"},      zero,      0);
    check({tag, "_div_zero"},  div_zero,  0);
`ifdef SEQ_ALU_REM_EN
    check({tag, "_remainder"}, remainder, 0);
`endif
  endtask

  exp_t m;

  initial begin
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_rst");

    // Hand-computed values that pin the model.
    m = model(OP_ADD, 8'd200, 8'd100);
    check("pin_add_res", m.res, 44);   check("pin_add_c", m.carry, 1);
    m = model(OP_SUB, 8'd5, 8'd7);
    check("pin_sub_res", m.res, 8'hFE); check("pin_sub_c", m.carry, 1);
    m = model(OP_MUL, 8'd16, 8'd16);
    check("pin_mul_z", m.zero, 1);     check("pin_mul_c", m.carry, 1);
    m = model(OP_DIV, 8'd200, 8'd7);
    check("pin_div_res", m.res, 28);   check("pin_div_rem", m.rem, 4);
    check("pin_div_lat", m.lat, 9);
    m = model(OP_DIV, 8'd37, 8'd0);
    check("pin_dz_res", m.res, 8'hFF); check("pin_dz_flag", m.dz, 1);
    m = model(OP_NOT, 8'h0F, 8'h33);
    check("pin_not_res", m.res, 8'hF0);

    // Directed operations, scored against the model.
    issue(OP_ADD, 8'd200, 8'd100); drain();
    issue(OP_SUB, 8'd5,   8'd7);   drain();
    issue(OP_SUB, 8'd9,   8'd9);   drain();
    issue(OP_MUL, 8'd16,  8'd16);  drain();
    issue(OP_MUL, 8'd15,  8'd17);  drain();
    issue(OP_DIV, 8'd200, 8'd7);   drain();
    issue(OP_DIV, 8'd37,  8'd0);   drain();
    issue(OP_NOT, 8'h0F,  8'h33);  drain();
    issue(OP_AND, 8'hF0,  8'h3C);  drain();
    issue(OP_OR,  8'h00,  8'h00);  drain();
    issue(OP_DIV, 8'd5,   8'd9);   drain();
    issue(OP_DIV, 8'd255, 8'd1);   drain();

    // Backpressure: outputs hold and no new op is accepted.
    @(posedge clk); #1 out_ready = 1'b0;
    issue(OP_XOR, 8'hAA, 8'hFF);
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_valid",    out_valid, 1);
      check("bp_result",   result, 8'h55);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    drain();

    // Reset in the middle of a divide.
    issue(OP_DIV, 8'd255, 8'd3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    q.delete();
    seen = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("after_mid_rst");
    repeat (12) @(negedge clk);
    check("no_stale_valid", out_valid, 0);

    issue(OP_ADD, 8'd1, 8'd2); drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
